// File: rtl/ysyx_24090018_exu_seq.sv
// Sequential execute unit: RV32I OP/OP-IMM ALU, iterative RV32M multiply/divide,
// sticky EBREAK flag, valid/ready handshakes on both sides.
module ysyx_24090018_exu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic [31:0]           inst_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  ebreak_o
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            negr_q, negr_d;
    logic [W-1:0]    a_q, a_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    rf_wdata_q, rf_wdata_d;
    logic            ebreak_q, ebreak_d;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [SW-1:0]   shamt;
    logic            is_imm, is_op, is_m, is_mul, is_div, is_ebreak;
    logic            a_signed, b_signed, div_signed, sign1, sign2, op2_zero, div_ovf;
    logic [W-1:0]    mag1, mag2, alu_res;
    logic            unused_inst_bits;

    assign opcode     = inst_i[6:0];
    assign f3         = inst_i[14:12];
    assign f7         = inst_i[31:25];
    assign shamt      = op2_i[SW-1:0];
    assign is_imm     = (opcode == 7'b0010011);
    assign is_op      = (opcode == 7'b0110011);
    assign is_m       = is_op && (f7 == 7'b0000001);
    assign is_mul     = is_m && !f3[2];
    assign is_div     = is_m && f3[2];
    assign is_ebreak  = (opcode == 7'b1110011) && (f3 == 3'b000) && inst_i[20];
    assign unused_inst_bits = ^{inst_i[24:21], inst_i[19:15], inst_i[11:7]};

    assign a_signed   = (f3 == 3'b001) || (f3 == 3'b010);
    assign b_signed   = (f3 == 3'b001);
    assign div_signed = !f3[0];
    assign sign1      = op1_i[W-1] && (is_mul ? a_signed : div_signed);
    assign sign2      = op2_i[W-1] && (is_mul ? b_signed : div_signed);
    assign mag1       = sign1 ? -op1_i : op1_i;
    assign mag2       = sign2 ? -op2_i : op2_i;
    assign op2_zero   = (op2_i == '0);
    assign div_ovf    = div_signed && (op1_i == {1'b1, {(W-1){1'b0}}}) && (op2_i == '1);

    always_comb begin
        alu_res = '0;
        if (is_imm || (is_op && f7 == 7'b0000000)) begin
            unique case (f3)
                3'b000: alu_res = op1_i + op2_i;
                3'b001: alu_res = op1_i << shamt;
                3'b010: alu_res = W'($signed(op1_i) < $signed(op2_i));
                3'b011: alu_res = W'(op1_i < op2_i);
                3'b100: alu_res = op1_i ^ op2_i;
                3'b101: alu_res = inst_i[30] ? W'($signed(op1_i) >>> shamt) : (op1_i >> shamt);
                3'b110: alu_res = op1_i | op2_i;
                3'b111: alu_res = op1_i & op2_i;
                default: alu_res = '0;
            endcase
        end else if (is_op && f7 == 7'b0100000) begin
            if (f3 == 3'b000)      alu_res = op1_i - op2_i;
            else if (f3 == 3'b101) alu_res = W'($signed(op1_i) >>> shamt);
        end
    end

    // One shift-add step: acc holds {partial high, remaining multiplier bits}.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, mul_prod;
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
    assign mul_prod = neg_q ? -mul_next : mul_next;

    // One restoring-division step: acc holds {remainder, dividend/quotient bits}.
    logic [W:0]     div_r;
    logic [W-1:0]   div_sub, quo, rem;
    logic           div_ge;
    logic [2*W-1:0] div_next;
    assign div_r    = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_ge   = (div_r >= {1'b0, a_q});
    assign div_sub  = div_r[W-1:0] - a_q;
    assign div_next = {(div_ge ? div_sub : div_r[W-1:0]), acc_q[W-2:0], div_ge};
    assign quo      = neg_q  ? -div_next[W-1:0]   : div_next[W-1:0];
    assign rem      = negr_q ? -div_next[2*W-1:W] : div_next[2*W-1:W];

    // NOTE: every _d gets its _q as default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        f3_d       = f3_q;
        neg_d      = neg_q;
        negr_d     = negr_q;
        a_d        = a_q;
        acc_d      = acc_q;
        rf_wdata_d = rf_wdata_q;
        ebreak_d   = ebreak_q;
        unique case (state_q)
            S_IDLE: if (in_valid_i) begin
                f3_d  = f3;
                neg_d = sign1 ^ sign2;
                if (is_mul) begin
                    a_d     = mag1;
                    acc_d   = {{W{1'b0}}, mag2};
                    cnt_d   = SW'(W - 1);
                    state_d = S_MUL;
                end else if (is_div && op2_zero) begin
                    rf_wdata_d = f3[1] ? op1_i : '1;
                    state_d    = S_DONE;
                end else if (is_div && div_ovf) begin
                    rf_wdata_d = f3[1] ? '0 : op1_i;
                    state_d    = S_DONE;
                end else if (is_div) begin
                    a_d     = mag2;
                    acc_d   = {{W{1'b0}}, mag1};
                    negr_d  = sign1;
                    cnt_d   = SW'(W - 1);
                    state_d = S_DIV;
                end else begin
                    rf_wdata_d = alu_res;
                    ebreak_d   = ebreak_q || is_ebreak;
                    state_d    = S_DONE;
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                if (cnt_q == '0) begin
                    rf_wdata_d = (f3_q == 3'b000) ? mul_prod[W-1:0] : mul_prod[2*W-1:W];
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                if (cnt_q == '0) begin
                    rf_wdata_d = f3_q[1] ? rem : quo;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            f3_q       <= '0;
            neg_q      <= 1'b0;
            negr_q     <= 1'b0;
            a_q        <= '0;
            acc_q      <= '0;
            rf_wdata_q <= '0;
            ebreak_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            f3_q       <= f3_d;
            neg_q      <= neg_d;
            negr_q     <= negr_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            rf_wdata_q <= rf_wdata_d;
            ebreak_q   <= ebreak_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign rf_wdata_o  = rf_wdata_q;
    assign ebreak_o    = ebreak_q;
endmodule

// File: doc/ysyx_24090018_exu_seq.md
# ysyx_24090018_exu_seq

Sequential, parametrised execute unit for the ysyx_24090018 core: it replaces the single-cycle combinational EXU with a valid/ready-handshaked block. It covers the full RV32I OP/OP-IMM integer set, an iterative RV32M multiplier/divider and a registered, sticky ebreak flag. It sits between IDU (which supplies operands and the raw instruction) and WBU (which consumes the register-file write data).

## Interface
- DATA_WIDTH, 32, operand/result width; must be a power of two, ≥ 8; shift amount uses low $clog2(DATA_WIDTH) bits of op2.

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid_i  input  1  IDU presents an instruction
- in_ready_o  output  1  EXU accepts; transfer when in_valid_i && in_ready_o
- op1_i  input  DATA_WIDTH  rs1 value
- op2_i  input  DATA_WIDTH  rs2 value or sign-extended immediate (IDU selects)
- inst_i  input  32  raw instruction; opcode [6:0], funct3 [14:12], funct7 [31:25]
- out_valid_o  output  1  result valid
- out_ready_i  input  1  WBU consumes; transfer when out_valid_o && out_ready_i
- rf_wdata_o  output  DATA_WIDTH  result, held stable while out_valid_o && !out_ready_i
- ebreak_o  output  1  sticky: set when an EBREAK completes, cleared only by reset

## Operation
- Operands, inst and decoded op class are captured on input transfer; inputs are ignored otherwise.
- States: IDLE, MUL, DIV, DONE. in_ready_o = (state==IDLE); out_valid_o = (state==DONE).
- IDLE + transfer: ALU/SYSTEM/unsupported → DONE; MUL* → MUL; DIV*/REM* → DIV, except special cases → DONE.
- MUL/DIV: counter loads DATA_WIDTH-1 and decrements each cycle; at 0 → DONE.
- DONE: out_ready_i=1 → IDLE; else hold.
- OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI (inst[30]=1 → SRAI).
- OP (0110011), funct7 0000000: ADD SLL SLT SLTU XOR SRL OR AND; 0100000: SUB (f3 000), SRA (f3 101); 0000001: M extension; any other funct7 → 0.
- M ext: MUL low W bits; MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned, upper W bits of the 2W-bit exact product. Internal algorithm is free; results and cycle count are fixed.
- DIV/DIVU/REM/REMU round toward zero; remainder takes sign of dividend.
- Divisor 0: quotient all ones, remainder = op1. Signed overflow (op1 = most-negative, op2 = -1): quotient = op1, remainder 0. Both take the 1-cycle path.
- SYSTEM (1110011), funct3 000: inst[20]=1 (EBREAK) → result 0, ebreak_o set on entering DONE; inst[20]=0 (ECALL) → result 0, no flag.
- Any other opcode/funct3 → result 0, 1-cycle path, no flag.
- All arithmetic is modulo 2^DATA_WIDTH; comparisons return 1 or 0 zero-extended.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, in_ready_o=1, out_valid_o=0, rf_wdata_o=0, ebreak_o=0, counter 0. Reset during MUL/DIV/DONE aborts the operation and discards the result.
- ALU, SYSTEM, unsupported and special-case divide: out_valid_o rises 1 cycle after input transfer.
- MUL*, normal DIV*/REM*: out_valid_o rises DATA_WIDTH+1 cycles after input transfer (33 at default).
- in_ready_o is low from the cycle after acceptance until the cycle after output transfer. Peak throughput is one ALU op per 2 cycles.
- out_valid_o never drops without an output transfer; rf_wdata_o never changes while out_valid_o=1.
- in_valid_i asserted while in_ready_o=0 has no effect; IDU must hold it.
- ebreak_o rises in the same cycle out_valid_o rises for the EBREAK.

## Test plan
- Reset, then ADDI op1=5 op2=0xFFFFFFFF (-1) → out_valid_o 1 cycle later, rf_wdata_o=4. Then SRAI op1=0x80000000 op2=4 → 0xF8000000.
- MULH op1=0x80000000 op2=0x80000000 → 0x40000000 after 33 cycles. MULHU op1=0xFFFFFFFF op2=0xFFFFFFFF → 0xFFFFFFFE. MUL of the same operands → 0x00000001.
- DIV op1=-7 op2=2 → 0xFFFFFFFD (-3), 33 cycles. REM of the same operands → 0xFFFFFFFF (-1). DIVU op1=7 op2=0 → 0xFFFFFFFF, 1 cycle. REM op1=0x80000000 op2=-1 → 0, 1 cycle.
- Backpressure: hold out_ready_i=0 for 10 cycles after SLTU op1=1 op2=2 → rf_wdata_o stays 1, in_ready_o stays 0; new in_valid_i is not accepted until out_ready_i=1.
- EBREAK inst=0x00100073 → rf_wdata_o=0, ebreak_o=1 and stays 1 across further ops. ECALL inst=0x00000073 → ebreak_o unchanged. Unknown opcode → result 0 in 1 cycle.
- Assert rst_n low mid-DIV (cycle 10) → all outputs return to reset values immediately. After release, a new ADD of 2+3 → 5.
